// File: rtl/frame_sync_packer.sv
// frame_sync_packer: takes the serial decoded-bit stream, hunts for the frame
// sync word, packs the following payload bits MSB-first into bytes and queues
// them in a small first-word-fall-through FIFO with start/end-of-frame flags.
module frame_sync_packer #(
    parameter logic [15:0] SYNC_WORD   = 16'hEB90,
    parameter int          FRAME_BYTES = 32,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec_val,
    input  logic       dec_bit,
    output logic       dec_rdy,
    output logic [7:0] byte_data,
    output logic       byte_sof,
    output logic       byte_eof,
    output logic       byte_val,
    input  logic       byte_rdy,
    output logic       locked,
    output logic [7:0] frame_count
);

    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]        LAST_BYTE = 8'(FRAME_BYTES - 1);

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    // FIFO entry layout: {eof, sof, data[7:0]}
    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic       accept;
    logic       push;
    logic       pop;
    logic [9:0] push_word;
    logic [9:0] head;

    // A byte-completing bit is only accepted when the FIFO has room, so push never overflows.
    assign dec_rdy = !reset && (count_q < DEPTH_C);
    assign accept  = dec_val && dec_rdy;

    assign byte_val  = (count_q != '0);
    assign pop       = byte_val && byte_rdy;
    assign head      = mem_q[rd_ptr_q];
    assign byte_data = byte_val ? head[7:0] : 8'h00;
    assign byte_sof  = byte_val && head[8];
    assign byte_eof  = byte_val && head[9];

    assign locked      = (state_q == PAYLOAD);
    assign frame_count = frame_cnt_q;

    // Framer state register and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            acc_q       <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic: sync hunting, bit packing and byte push generation.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        frame_cnt_d = frame_cnt_q;
        push        = 1'b0;
        push_word   = '0;
        if (accept) begin
            sr_d = {sr_q[14:0], dec_bit};
            case (state_q)
                HUNT: begin
                    if ({sr_q[14:0], dec_bit} == SYNC_WORD) begin
                        state_d    = PAYLOAD;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
                PAYLOAD: begin
                    acc_d     = {acc_q[6:0], dec_bit};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        push       = 1'b1;
                        push_word  = {(byte_cnt_q == LAST_BYTE), (byte_cnt_q == 8'd0),
                                      acc_q[6:0], dec_bit};
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            // Clearing sr stops payload tail bits from faking a sync.
                            state_d     = HUNT;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                            sr_d        = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO storage write; contents need no reset because byte_val gates the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sync_packer.sv
// Testbench for frame_sync_packer: two instances (4-byte and 1-byte frames),
// randomized bit/byte stimulus, a bit-level reference model feeding expected
// bytes into per-instance queues and a negedge monitor that checks outputs.
module tb_frame_sync_packer;

    localparam int FB0  = 4;
    localparam int FB1  = 1;
    localparam int DEP  = 4;
    localparam int SYNC = 'hEB90;

    logic       clk = 1'b0;
    logic       reset;
    logic       dv  [2];
    logic       db  [2];
    logic       br  [2];
    logic       rdy [2];
    logic       bv  [2];
    logic       bs  [2];
    logic       be  [2];
    logic       lk  [2];
    logic [7:0] bd  [2];
    logic [7:0] fc  [2];

    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode [2];   // 0 = hold low, 1 = hold high, 2 = random

    // Expected bytes, encoded as eof*512 + sof*256 + data.
    int q0[$];
    int q1[$];

    // Reference model state (per instance).
    int m_win    [2];
    bit m_in     [2];
    int m_nbits  [2];
    int m_val    [2];
    int m_nbytes [2];
    int m_frames [2];

    always #5 clk = ~clk;

    frame_sync_packer #(.SYNC_WORD(16'hEB90), .FRAME_BYTES(FB0), .FIFO_DEPTH(DEP)) dut0 (
        .clk(clk), .reset(reset), .dec_val(dv[0]), .dec_bit(db[0]), .dec_rdy(rdy[0]),
        .byte_data(bd[0]), .byte_sof(bs[0]), .byte_eof(be[0]), .byte_val(bv[0]),
        .byte_rdy(br[0]), .locked(lk[0]), .frame_count(fc[0])
    );

    frame_sync_packer #(.SYNC_WORD(16'hEB90), .FRAME_BYTES(FB1), .FIFO_DEPTH(DEP)) dut1 (
        .clk(clk), .reset(reset), .dec_val(dv[1]), .dec_bit(db[1]), .dec_rdy(rdy[1]),
        .byte_data(bd[1]), .byte_sof(bs[1]), .byte_eof(be[1]), .byte_val(bv[1]),
        .byte_rdy(br[1]), .locked(lk[1]), .frame_count(fc[1])
    );

    function automatic int fb(int u);
        return (u == 0) ? FB0 : FB1;
    endfunction

    function automatic int q_size(int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int q_front(int u);
        return (u == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_pop(int u);
        if (u == 0) q0.delete(0);
        else        q1.delete(0);
    endfunction

    function automatic void q_push(int u, int v);
        if (u == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic void chk(string name, int u, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s u%0d: got %0h expected %0h at %0t", name, u, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        for (int u = 0; u < 2; u++) begin
            m_win[u] = 0; m_in[u] = 0; m_nbits[u] = 0;
            m_val[u] = 0; m_nbytes[u] = 0; m_frames[u] = 0;
        end
    endfunction

    // Model of one accepted bit: sliding 16-bit window in hunt, arithmetic byte build in payload.
    function automatic void model_bit(int u, bit b);
        int sof, eof;
        if (!m_in[u]) begin
            m_win[u] = (m_win[u] * 2 + int'(b)) % 65536;
            if (m_win[u] == SYNC) begin
                m_in[u] = 1; m_nbits[u] = 0; m_val[u] = 0; m_nbytes[u] = 0;
            end
        end else begin
            m_val[u] = m_val[u] * 2 + int'(b);
            m_nbits[u]++;
            if (m_nbits[u] == 8) begin
                sof = (m_nbytes[u] == 0) ? 1 : 0;
                eof = (m_nbytes[u] == fb(u) - 1) ? 1 : 0;
                q_push(u, eof * 512 + sof * 256 + m_val[u]);
                m_nbytes[u]++;
                m_nbits[u] = 0;
                m_val[u]   = 0;
                if (eof == 1) begin
                    m_in[u]     = 0;
                    m_win[u]    = 0;
                    m_frames[u] = (m_frames[u] + 1) % 256;
                end
            end
        end
    endfunction

    // byte_rdy driver: sole writer of br, following rdy_mode.
    initial begin
        br[0] = 1'b1;
        br[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++)
                br[u] = (rdy_mode[u] == 2) ? 1'($urandom_range(1)) : (rdy_mode[u] == 1);
        end
    end

    // Monitor: compares handshake, status and FIFO head against the model every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            for (int u = 0; u < 2; u++) begin
                int occ;
                int e;
                occ = q_size(u);
                chk("dec_rdy", u, int'(rdy[u]), (occ < DEP) ? 1 : 0);
                chk("locked", u, int'(lk[u]), int'(m_in[u]));
                chk("frame_count", u, int'(fc[u]), m_frames[u]);
                chk("byte_val", u, int'(bv[u]), (occ != 0) ? 1 : 0);
                if (bv[u] && occ != 0) begin
                    e = q_front(u);
                    chk("byte_data", u, int'(bd[u]), e % 256);
                    chk("byte_sof", u, int'(bs[u]), (e / 256) % 2);
                    chk("byte_eof", u, int'(be[u]), e / 512);
                    if (br[u]) q_pop(u);
                end
            end
        end
    end

    task automatic idle(int u, int k);
        dv[u] = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(int u, bit b);
        int  n;
        bit  taken;
        n     = 0;
        taken = 0;
        dv[u] = 1'b1;
        db[u] = b;
        while (!taken) begin
            @(negedge clk);
            taken = rdy[u];
            @(posedge clk);
            #1;
            if (!taken) begin
                n++;
                if (n > 300) begin
                    chk("accept_timeout", u, 1, 0);
                    break;
                end
            end
        end
        dv[u] = 1'b0;
        if (taken) model_bit(u, b);
    endtask

    task automatic send_bits(int u, int w, int nbits, bit gap);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (gap && $urandom_range(1) == 1) idle(u, int'($urandom_range(1, 2)));
            send_bit(u, w[i]);
        end
    endtask

    task automatic send_frame(int u, bit gap);
        send_bits(u, SYNC, 16, gap);
        for (int i = 0; i < fb(u); i++) send_bits(u, int'($urandom_range(255)), 8, gap);
    endtask

    task automatic wait_drain(int u);
        int n;
        n = 0;
        while (q_size(u) != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", u, q_size(u), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            dv[u] = 1'b0; db[u] = 1'b0; rdy_mode[u] = 1;
        end
        model_reset();
        #2;
        for (int u = 0; u < 2; u++) begin
            chk("rst_byte_val", u, int'(bv[u]), 0);
            chk("rst_byte_data", u, int'(bd[u]), 0);
            chk("rst_sof_eof", u, int'({bs[u], be[u]}), 0);
            chk("rst_locked", u, int'(lk[u]), 0);
            chk("rst_frame_count", u, int'(fc[u]), 0);
            chk("rst_dec_rdy", u, int'(rdy[u]), 0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Sync plus one frame, fixed payload.
        send_bits(0, SYNC, 16, 0);
        send_bits(0, 'h12, 8, 0);
        send_bits(0, 'h34, 8, 0);
        send_bits(0, 'h56, 8, 0);
        send_bits(0, 'h78, 8, 0);
        wait_drain(0);
        chk("t1_frames", 0, int'(fc[0]), 1);
        $display("tx: sync + 12 34 56 78, frame_count=%0d", fc[0]);

        // Near-miss patterns must not lock.
        send_bits(0, 'hEB91, 16, 0);
        send_bits(0, 'h5A5A, 16, 0);
        chk("t2_no_lock", 0, int'(lk[0]), 0);
        send_frame(0, 0);
        wait_drain(0);
        chk("t2_frames", 0, int'(fc[0]), 2);
        $display("tx: EB91 5A5A then frame, frame_count=%0d", fc[0]);

        // Backpressure: two frames with byte_rdy low; FIFO fills and stalls input.
        rdy_mode[0] = 0;
        fork
            begin
                send_frame(0, 0);
                send_frame(0, 0);
            end
            begin
                repeat (100) @(posedge clk);
                #1;
                chk("t3_stall_rdy", 0, int'(rdy[0]), 0);
                chk("t3_full_val", 0, int'(bv[0]), 1);
                rdy_mode[0] = 1;
            end
        join
        wait_drain(0);
        chk("t3_frames", 0, int'(fc[0]), 4);
        $display("tx: backpressured 2 frames, frame_count=%0d", fc[0]);

        // Random gaps, random byte_rdy, random noise before each frame.
        rdy_mode[0] = 2;
        for (int f = 0; f < 4; f++) begin
            send_bits(0, int'($urandom_range(255)), 8, 1);
            send_frame(0, 1);
            $display("tx: random gapped frame %0d, pending=%0d", f, q_size(0));
        end
        rdy_mode[0] = 1;
        wait_drain(0);
        chk("t4_frames", 0, int'(fc[0]), m_frames[0]);

        // Sync pattern inside payload is data, not a re-hunt.
        send_bits(0, SYNC, 16, 0);
        send_bits(0, 'hEB90, 16, 0);
        send_bits(0, 'h0001, 16, 0);
        send_bits(0, SYNC, 16, 0);
        send_bits(0, 'hFFFF, 16, 0);
        send_bits(0, 'hFFFF, 16, 0);
        wait_drain(0);
        chk("t5_frames", 0, int'(fc[0]), m_frames[0]);
        $display("tx: sync-in-payload frames, frame_count=%0d", fc[0]);

        // One-byte frames: gapped and gapless must give the same sof+eof byte.
        send_bits(1, SYNC, 16, 1);
        send_bits(1, 'hA5, 8, 1);
        wait_drain(1);
        chk("t6_gap_frames", 1, int'(fc[1]), 1);
        send_bits(1, SYNC, 16, 0);
        send_bits(1, 'hA5, 8, 0);
        wait_drain(1);
        chk("t6_frames", 1, int'(fc[1]), 2);
        $display("tx: FRAME_BYTES=1 A5 gapped+gapless, frame_count=%0d", fc[1]);

        // Asynchronous reset mid-frame with a byte waiting in the FIFO.
        rdy_mode[0] = 0;
        send_bits(0, SYNC, 16, 0);
        send_bits(0, 'h3C, 8, 0);
        send_bits(0, 'h5, 3, 0);
        chk("t7_pre_locked", 0, int'(lk[0]), 1);
        chk("t7_pre_val", 0, int'(bv[0]), 1);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t7_async_val", 0, int'(bv[0]), 0);
        chk("t7_async_locked", 0, int'(lk[0]), 0);
        chk("t7_async_rdy", 0, int'(rdy[0]), 0);
        chk("t7_async_fc", 0, int'(fc[0]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_mode[0] = 1;
        send_frame(0, 0);
        wait_drain(0);
        chk("t7_frames", 0, int'(fc[0]), 1);
        $display("tx: async reset then fresh frame, frame_count=%0d", fc[0]);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
